// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// synchronous write ports, optional write-to-read bypass and a sequential clear engine.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// CLEAR | zeroing one entry per cycle at clr_cnt, writes ignored, reads return 0
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we0, we1, conflict_nxt;

  assign busy = (state == CLEAR);

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Writes to a hardwired zero register are dropped, and so never count as a conflict.
  assign we0 = wr0_en && !busy && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign we1 = wr1_en && !busy && !((ZERO_REG != 0) && (wr1_addr == '0));
  assign conflict_nxt = we0 && we1 && (wr0_addr == wr1_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (we0) mem[wr0_addr] <= wr0_data;
        if (we1) mem[wr1_addr] <= wr1_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (busy) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr1_en && (wr1_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
      end else if ((BYPASS != 0) && wr0_en && (wr0_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule
